// File: rtl/kb_scancode_ctrl.sv
// PS/2 scan-code sequencer: assembles make/break/extended events, tracks
// modifiers and lock LEDs, and queues events in a small valid/ready FIFO.
module kb_scancode_ctrl #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_keycode,
  input  logic       i_ready,
  output logic [2:0] o_led_status,
  output logic [5:0] o_modifiers,
  output logic       o_event_valid,
  input  logic       i_event_ready,
  output logic [7:0] o_event_code,
  output logic       o_event_ext,
  output logic       o_event_break,
  output logic       o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               skip_q, skip_d;
  logic [2:0]               led_q, led_d, held_q, held_d;
  logic [5:0]               mod_q, mod_d;
  logic                     ovf_q, ovf_d;
  evt_t [FIFO_DEPTH-1:0]    mem_q, mem_d;
  logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]              cnt_q, cnt_d;

  logic       is_ctrl, key_done, cur_ext, cur_brk, ev_push, lock_hit;
  logic [1:0] lock_idx;
  evt_t       ev_new;
  logic       pop, full, accept;

  assign is_ctrl = (i_keycode == 8'hFA) || (i_keycode == 8'hFE) || (i_keycode == 8'hEE) ||
                   (i_keycode == 8'h00) || (i_keycode == 8'hFF) || (i_keycode == 8'hAA);
  assign cur_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
  assign cur_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    led_d    = led_q;
    mod_d    = mod_q;
    held_d   = held_q;
    key_done = 1'b0;
    ev_push  = 1'b0;
    ev_new   = '0;
    lock_hit = 1'b0;
    lock_idx = 2'd0;
    if (i_ready) begin
      if (state_q == S_PAUSE) begin
        // Pause bytes are only counted; they never reach the key maps.
        if (skip_q == 3'd1) begin
          ev_push = 1'b1;
          ev_new  = '{code: 8'hE1, ext: 1'b1, brk: 1'b0};
          skip_d  = 3'd0;
          state_d = S_IDLE;
        end else begin
          skip_d = skip_q - 3'd1;
        end
      end else if (is_ctrl) begin
        state_d = S_IDLE;
        if (i_keycode == 8'hAA) begin
          led_d  = '0;
          mod_d  = '0;
          held_d = '0;
        end
      end else begin
        case (state_q)
          S_IDLE:
            if (i_keycode == 8'hE0)      state_d = S_EXT;
            else if (i_keycode == 8'hF0) state_d = S_BRK;
            else if (i_keycode == 8'hE1) begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end else key_done = 1'b1;
          S_EXT:
            if (i_keycode == 8'hF0)      state_d = S_EXT_BRK;
            else if (i_keycode != 8'hE0) key_done = 1'b1;
          S_BRK:
            if (i_keycode == 8'hE0)      state_d = S_EXT;
            else if (i_keycode != 8'hF0) key_done = 1'b1;
          S_EXT_BRK:
            if (i_keycode != 8'hF0 && i_keycode != 8'hE0) key_done = 1'b1;
          default: state_d = S_IDLE;
        endcase
      end
    end

    if (key_done) begin
      ev_push = 1'b1;
      ev_new  = '{code: i_keycode, ext: cur_ext, brk: cur_brk};
      state_d = S_IDLE;
      case ({cur_ext, i_keycode})
        9'h012: mod_d[0] = ~cur_brk;
        9'h059: mod_d[1] = ~cur_brk;
        9'h014: mod_d[2] = ~cur_brk;
        9'h114: mod_d[3] = ~cur_brk;
        9'h011: mod_d[4] = ~cur_brk;
        9'h111: mod_d[5] = ~cur_brk;
        9'h07E: begin lock_hit = 1'b1; lock_idx = 2'd0; end
        9'h077: begin lock_hit = 1'b1; lock_idx = 2'd1; end
        9'h058: begin lock_hit = 1'b1; lock_idx = 2'd2; end
        default: ;
      endcase
      // Held flag suppresses toggling on typematic repeats.
      if (lock_hit) begin
        if (cur_brk) held_d[lock_idx] = 1'b0;
        else if (!held_q[lock_idx]) begin
          led_d[lock_idx]  = ~led_q[lock_idx];
          held_d[lock_idx] = 1'b1;
        end
      end
    end
  end

  assign pop    = (cnt_q != '0) && i_event_ready;
  assign full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign accept = ev_push && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wr_q] = ev_new;
    wr_d  = wr_q + AW'(accept);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(accept) - (AW+1)'(pop);
    ovf_d = ev_push && full && !pop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      led_q   <= '0;
      mod_q   <= '0;
      held_q  <= '0;
      ovf_q   <= 1'b0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      led_q   <= led_d;
      mod_q   <= mod_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_led_status  = led_q;
  assign o_modifiers   = mod_q;
  assign o_overflow    = ovf_q;
  assign o_event_valid = (cnt_q != '0);
  assign o_event_code  = mem_q[rd_q].code;
  assign o_event_ext   = mem_q[rd_q].ext;
  assign o_event_break = mem_q[rd_q].brk;
endmodule

// File: tb/tb_kb_scancode_ctrl.sv
// Bench for kb_scancode_ctrl: directed vector table, FIFO/reset corner
// sequences, then random byte streams against an event-level model.
module tb_kb_scancode_ctrl;
  localparam int DEPTH = 8;

  logic       i_clk, i_rst_n, i_ready, i_event_ready;
  logic [7:0] i_keycode;
  logic [2:0] o_led_status;
  logic [5:0] o_modifiers;
  logic       o_event_valid, o_event_ext, o_event_break, o_overflow;
  logic [7:0] o_event_code;

  kb_scancode_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_keycode(i_keycode), .i_ready(i_ready),
    .o_led_status(o_led_status), .o_modifiers(o_modifiers),
    .o_event_valid(o_event_valid), .i_event_ready(i_event_ready),
    .o_event_code(o_event_code), .o_event_ext(o_event_ext),
    .o_event_break(o_event_break), .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_keycode = b;
    i_ready   = 1'b1;
    step();
    i_ready   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] kc;
    bit         ev;
    logic [7:0] code;
    bit         ext, brk;
    logic [2:0] led;
    logic [5:0] mods;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] kc, input bit ev, input logic [7:0] code,
                     input bit ext, input bit brk, input logic [2:0] led, input logic [5:0] mods);
    vec_t v;
    v.kc = kc; v.ev = ev; v.code = code; v.ext = ext; v.brk = brk; v.led = led; v.mods = mods;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t        mq[$];
  bit         m_ext, m_brk, m_ovf;
  int         m_pause;
  logic [2:0] m_led, m_held;
  logic [5:0] m_mod;
  logic [7:0] mod_code [6] = '{8'h12, 8'h59, 8'h14, 8'h14, 8'h11, 8'h11};
  bit         mod_ext  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] lock_code[3] = '{8'h7E, 8'h77, 8'h58};

  task automatic model_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_pause = 0;
    m_led = '0; m_held = '0; m_mod = '0;
  endtask

  task automatic model_key(input logic [7:0] c, input bit ext, input bit brk);
    for (int k = 0; k < 6; k++)
      if (c == mod_code[k] && ext == mod_ext[k]) m_mod[k] = !brk;
    for (int k = 0; k < 3; k++)
      if (!ext && c == lock_code[k]) begin
        if (brk) m_held[k] = 1'b0;
        else if (!m_held[k]) begin
          m_led[k]  = !m_led[k];
          m_held[k] = 1'b1;
        end
      end
  endtask

  task automatic model_step(input bit rdy, input logic [7:0] b, input bit evr);
    bit  push;
    ev_t e;
    push = 0; e = '0; m_ovf = 0;
    if (rdy) begin
      if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin push = 1; e = {8'hE1, 1'b1, 1'b0}; end
      end else if (b inside {8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hAA}) begin
        m_ext = 0; m_brk = 0;
        if (b == 8'hAA) begin m_led = '0; m_mod = '0; m_held = '0; end
      end else if (b == 8'hE0) begin
        if (!m_ext) begin m_ext = 1; m_brk = 0; end
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE1 && !m_ext && !m_brk) begin
        m_pause = 7;
      end else begin
        push = 1;
        e = {b, m_ext, m_brk};
        model_key(b, m_ext, m_brk);
        m_ext = 0; m_brk = 0;
      end
    end
    if (evr && mq.size() > 0) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1;
    end
  endtask

  task automatic model_cmp();
    chk("rnd_led", o_led_status, m_led);
    chk("rnd_mod", o_modifiers, m_mod);
    chk("rnd_ovf", o_overflow, m_ovf);
    chk("rnd_valid", o_event_valid, mq.size() > 0);
    if (mq.size() > 0) chk("rnd_head", {o_event_code, o_event_ext, o_event_break}, mq[0]);
  endtask

  logic [7:0] pool[18] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h77, 8'h7E, 8'hE0, 8'hF0,
                           8'hE1, 8'hFA, 8'hAA, 8'h1C, 8'h15, 8'hE0, 8'hF0, 8'h14, 8'h58};
  logic [7:0] fc[9] = '{8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h21, 8'h22};

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0; i_ready = 1'b0; i_event_ready = 1'b0; i_keycode = 8'h00;
    #3;
    chk("rst_led", o_led_status, 3'd0);
    chk("rst_mod", o_modifiers, 6'd0);
    chk("rst_valid", o_event_valid, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    step();
    i_rst_n = 1'b1;
    step();

    add(8'h1C,1,8'h1C,0,0,3'b000,6'h00); add(8'hF0,0,0,0,0,3'b000,6'h00);
    add(8'h1C,1,8'h1C,0,1,3'b000,6'h00);
    add(8'hE0,0,0,0,0,3'b000,6'h00); add(8'h14,1,8'h14,1,0,3'b000,6'h08);
    add(8'hE0,0,0,0,0,3'b000,6'h08); add(8'hF0,0,0,0,0,3'b000,6'h08);
    add(8'h14,1,8'h14,1,1,3'b000,6'h00);
    add(8'h58,1,8'h58,0,0,3'b100,6'h00); add(8'h58,1,8'h58,0,0,3'b100,6'h00);
    add(8'h58,1,8'h58,0,0,3'b100,6'h00); add(8'hF0,0,0,0,0,3'b100,6'h00);
    add(8'h58,1,8'h58,0,1,3'b100,6'h00); add(8'h58,1,8'h58,0,0,3'b000,6'h00);
    add(8'h77,1,8'h77,0,0,3'b010,6'h00); add(8'h12,1,8'h12,0,0,3'b010,6'h01);
    add(8'hE1,0,0,0,0,3'b010,6'h01); add(8'h14,0,0,0,0,3'b010,6'h01);
    add(8'h77,0,0,0,0,3'b010,6'h01); add(8'hE1,0,0,0,0,3'b010,6'h01);
    add(8'hF0,0,0,0,0,3'b010,6'h01); add(8'h14,0,0,0,0,3'b010,6'h01);
    add(8'hF0,0,0,0,0,3'b010,6'h01); add(8'h77,1,8'hE1,1,0,3'b010,6'h01);
    add(8'hF0,0,0,0,0,3'b010,6'h01); add(8'hE0,0,0,0,0,3'b010,6'h01);
    add(8'h1C,1,8'h1C,1,0,3'b010,6'h01);
    add(8'hE0,0,0,0,0,3'b010,6'h01); add(8'hFA,0,0,0,0,3'b010,6'h01);
    add(8'h1C,1,8'h1C,0,0,3'b010,6'h01); add(8'h59,1,8'h59,0,0,3'b010,6'h03);
    add(8'hAA,0,0,0,0,3'b000,6'h00); add(8'h1C,1,8'h1C,0,0,3'b000,6'h00);

    foreach (tbl[i]) begin
      send(tbl[i].kc);
      chk($sformatf("vec%0d_led", i), o_led_status, tbl[i].led);
      chk($sformatf("vec%0d_mod", i), o_modifiers, tbl[i].mods);
      chk($sformatf("vec%0d_valid", i), o_event_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_event", i), {o_event_code, o_event_ext, o_event_break},
            {tbl[i].code, tbl[i].ext, tbl[i].brk});
        i_event_ready = 1'b1;
        step();
        i_event_ready = 1'b0;
        chk($sformatf("vec%0d_popped", i), o_event_valid, 1'b0);
      end
    end

    // FIFO full, overflow, and simultaneous push/pop while full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(fc[i]);
      chk($sformatf("fill%0d_ovf", i), o_overflow, i == 8);
    end
    step();
    chk("full_ovf_drop", o_overflow, 1'b0);
    chk("full_head", o_event_code, 8'h15);
    i_keycode = 8'h23; i_ready = 1'b1; i_event_ready = 1'b1;
    step();
    i_ready = 1'b0; i_event_ready = 1'b0;
    chk("pushpop_ovf", o_overflow, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] exp_c;
      exp_c = (i == 8) ? 8'h23 : fc[i];
      chk($sformatf("drain%0d_valid", i), o_event_valid, 1'b1);
      chk($sformatf("drain%0d_code", i), o_event_code, exp_c);
      i_event_ready = 1'b1;
      step();
      i_event_ready = 1'b0;
    end
    chk("drain_empty", o_event_valid, 1'b0);

    // reset mid-sequence
    send(8'h58); send(8'h12); send(8'hE0);
    i_rst_n = 1'b0;
    #2;
    chk("midrst_led", o_led_status, 3'd0);
    chk("midrst_mod", o_modifiers, 6'd0);
    chk("midrst_valid", o_event_valid, 1'b0);
    chk("midrst_head", {o_event_code, o_event_ext, o_event_break}, 10'd0);
    step();
    i_rst_n = 1'b1;
    step();
    send(8'h1C);
    chk("midrst_valid2", o_event_valid, 1'b1);
    chk("midrst_event", {o_event_code, o_event_ext, o_event_break}, {8'h1C, 2'b00});

    // random streams against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit         rdy, evr;
      logic [7:0] b;
      int         r, ph;
      rdy = ($urandom % 10) < 6;
      r   = $urandom % 22;
      b   = (r < 18) ? pool[r] : 8'($urandom);
      ph  = (i / 200) % 3;
      evr = ($urandom % 10) < ((ph == 0) ? 1 : (ph == 1) ? 5 : 9);
      model_step(rdy, b, evr);
      i_keycode = b; i_ready = rdy; i_event_ready = evr;
      step();
      model_cmp();
    end
    i_ready = 1'b0; i_event_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kb_scancode_ctrl.md
# kb_scancode_ctrl

Scan-code sequencer between the PS/2 receiver and the rest of the system. It consumes the raw byte stream (`i_keycode`/`i_ready`) from `kb_interface` and assembles make/break/extended key events. It tracks modifier keys and owns the Caps/Num/Scroll lock state, which it drives back to `kb_interface` as `i_led_status`. Completed events go into a small FIFO and are presented to the consumer with a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of 2 and ≥ 2.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_keycode`  in  8  received byte; valid only in the `i_ready` cycle.
- `i_ready`  in  1  one-cycle byte strobe from `kb_interface`.
- `o_led_status`  out  3  to `kb_interface.i_led_status`; bit0 Scroll, bit1 Num, bit2 Caps.
- `o_modifiers`  out  6  held state; bit0 LShift, bit1 RShift, bit2 LCtrl, bit3 RCtrl, bit4 LAlt, bit5 RAlt.
- `o_event_valid`  out  1  FIFO non-empty.
- `i_event_ready`  in  1  consumer pop.
- `o_event_code`  out  8  base scan code of the head event.
- `o_event_ext`  out  1  head event was E0-prefixed; also set for Pause.
- `o_event_break`  out  1  head event is a release.
- `o_overflow`  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Reset values:** all outputs 0. Decoder FSM in `IDLE`. FIFO empty. Lock-held flags 0.
- **Decoder FSM**, advances only in `i_ready` cycles:
  - `IDLE`: E0 → `EXT`; F0 → `BRK`; E1 → `PAUSE` (skip count 7); any other byte → complete event (ext=0, brk=0).
  - `EXT`: F0 → `EXT_BRK`; E0 → stay; other byte → complete event (ext=1, brk=0).
  - `BRK`: F0 → stay; E0 → `EXT`; other byte → complete event (ext=0, brk=1).
  - `EXT_BRK`: F0/E0 → stay; other byte → complete event (ext=1, brk=1).
  - `PAUSE`: each byte decrements the skip count. When the count reaches 0, emit event code E1, ext=1, brk=0, then go to `IDLE`. Bytes swallowed here never touch lock or modifier state (the sequence contains 14 and 77).
- **Control bytes:** FA, FE, EE, 00 and FF arriving in any state other than `PAUSE` are dropped, FSM → `IDLE`, no event. AA (BAT) is handled the same way and also clears `o_led_status`, `o_modifiers` and the held flags.
- **Modifier map** (set on make, clear on break):
  - LShift: 12, ext=0
  - RShift: 59, ext=0
  - LCtrl: 14, ext=0
  - RCtrl: 14, ext=1
  - LAlt: 11, ext=0
  - RAlt: 11, ext=1
- **Lock keys:** Caps 58, Num 77, Scroll 7E, all ext=0.
  - Make with held flag = 0: toggle the LED bit and set the held flag.
  - Make with held flag = 1: typematic repeat; no toggle.
  - Break: clear the held flag.
- **FIFO:** every completed event is pushed `{code, ext, brk}`. Head fields are driven combinationally from the head entry. A pop occurs when `o_event_valid && i_event_ready`.
- **Full FIFO:** the new event is dropped and `o_overflow` pulses, unless a pop occurs in the same cycle, in which case the push is accepted. LED and modifier updates happen regardless of whether the event is dropped.
- **Empty FIFO:** `i_event_ready` is ignored.

## Timing
- Every state, LED, modifier and FIFO update is registered in the cycle where `i_ready` = 1 (cycle N). New values are visible at N+1.
- Event latency: final byte strobe in cycle N → `o_event_valid` = 1 in N+1 (FIFO previously empty).
- `o_overflow` is high for exactly cycle N+1.
- `i_ready` and a pop may coincide in the same cycle; the count is updated by +1, −1 or 0 as appropriate.
- `o_led_status` is stable until the next lock toggle. `kb_interface` samples it roughly 1 ms after the lock byte arrives, which is well after the N+1 update.
- Asserting `i_rst_n` low mid-sequence (for example after E0, or inside `PAUSE`) immediately returns the block to its reset state. No partial event is emitted.

## Test plan
- **Plain make/break:** bytes 1C, F0, 1C → two events: {1C, ext 0, brk 0} then {1C, ext 0, brk 1}. Each `o_event_valid` rises one cycle after its strobe.
- **Extended keys and modifiers:** E0, 14 → `o_modifiers` = 6'b001000 and event {14, 1, 0}. Then E0, F0, 14 → `o_modifiers` = 0 and event {14, 1, 1}.
- **Lock toggle and typematic:** 58, 58, 58, F0, 58, 58 → `o_led_status` goes 100, stays 100 through the repeats, then becomes 000 after the final make. 77 → 010. AA → 000.
- **Pause:** E1, 14, 77, E1, F0, 14, F0, 77 → exactly one event {E1, 1, 0}. `o_led_status` and `o_modifiers` are unchanged.
- **FIFO boundaries:** with `i_event_ready` = 0, send 9 make codes (`FIFO_DEPTH` = 8) → 8 events stored, one `o_overflow` pulse, and the head is still the first code. With the FIFO full, a simultaneous push and pop is accepted with no overflow pulse.
- **Reset mid-sequence:** send E0, assert `i_rst_n` low, release, then send 1C → event {1C, ext 0, brk 0}, and all outputs were 0 during reset.
